mdu: RTL and testbench

Multiply/divide unit for the E stage of the pipelined MIPS core. It executes mult, multu, div, divu, mthi and mtlo against private HI/LO registers, and exposes HI/LO for mfhi/mflo. Results reach the register file through the normal E→M→W path. A multi-cycle Busy window drives the hazard unit's stall of any MD-class instruction.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mdu_arith.sv | 52 +++++
 rtl/mdu.sv | 111 +++++++++++
 tb/tb_mdu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU operation codes and default latencies; the controller emits the same codes.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_start_op(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the {HI, LO} pair for a launch op.
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        ok_o
);

  logic [63:0] prod;
  logic        signed_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    prod       = '0;
    hi_o       = '0;
    lo_o       = '0;
    ok_o       = 1'b1;
    signed_div = (op_i == OP_DIV);

    case (op_i)
      OP_MULT:  prod = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
      OP_MULTU: prod = {32'b0, a_i} * {32'b0, b_i};
      default:  prod = '0;
    endcase

    // Signed divide goes through magnitudes so 0x80000000 / -1 wraps cleanly
    // instead of relying on signed overflow behaviour of the simulator.
    mag_a   = (signed_div && a_i[31]) ? (32'd0 - a_i) : a_i;
    mag_b   = (signed_div && b_i[31]) ? (32'd0 - b_i) : b_i;
    divisor = (b_i == '0) ? 32'd1 : mag_b;
    quo     = mag_a / divisor;
    rem     = mag_a % divisor;

    if (is_div_op(op_i)) begin
      lo_o = (signed_div && (a_i[31] ^ b_i[31])) ? (32'd0 - quo) : quo;
      hi_o = (signed_div && a_i[31]) ? (32'd0 - rem) : rem;
      ok_o = (b_i != '0);
    end else begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end
  end

endmodule

// File: rtl/mdu.sv
// E-stage multiply/divide unit: HI/LO registers, multi-cycle Busy window, mfhi/mflo read port.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_Op,
  input  logic        Start,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] Out
);

  localparam int unsigned MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  mdu_op_e       op;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   phi_q, phi_d;
  logic [31:0]   plo_q, plo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          commit_q, commit_d;
  logic          idle_ok;
  logic          accept;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          res_ok;

  assign op = mdu_op_e'(MDU_Op);

  mdu_arith u_arith (
    .op_i (op),
    .a_i  (A),
    .b_i  (B),
    .hi_o (res_hi),
    .lo_o (res_lo),
    .ok_o (res_ok)
  );

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    phi_d    = phi_q;
    plo_d    = plo_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    idle_ok  = !busy_q && !Req;
    accept   = Start && idle_ok && is_start_op(op);

    if (accept) begin
      phi_d    = res_hi;
      plo_d    = res_lo;
      commit_d = res_ok;
      cnt_d    = is_div_op(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      // Divide-by-zero still runs the full window but never commits.
      if (cnt_q == CW'(1) && commit_q) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end else if (idle_ok) begin
      if (op == OP_MTHI) hi_d = A;
      if (op == OP_MTLO) lo_d = A;
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      phi_q    <= '0;
      plo_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      phi_q    <= phi_d;
      plo_q    <= plo_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    case (op)
      OP_MFHI: Out = hi_q;
      OP_MFLO: Out = lo_q;
      default: Out = '0;
    endcase
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: multiply/divide results, Busy window, blocking and reset cases.
module tb_mdu;
  import mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  MDU_Op;
  logic        Start;
  logic        Req;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  int unsigned checks      = 0;
  int unsigned failures    = 0;
  int unsigned busy_cycles = 0;

  always #5 Clk = ~Clk;

  mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .A      (A),
    .B      (B),
    .MDU_Op (MDU_Op),
    .Start  (Start),
    .Req    (Req),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .Out    (Out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (Busy) busy_cycles++;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic rq);
    MDU_Op = op;
    A      = a;
    B      = b;
    Start  = st;
    Req    = rq;
  endtask

  task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b, 1'b1, 1'b0);
    busy_cycles = 0;
    tick();
    drive(OP_NONE, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && Busy; i++) tick();
    chk({tag, "_idle"}, {31'b0, Busy}, 32'd0);
  endtask

  initial begin
    drive(OP_NONE, '0, '0, 1'b0, 1'b0);
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
    MDU_Op = OP_MFLO;
    #1;
    chk("rst_busy", {31'b0, Busy}, 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_out", Out, 32'h0);

    // Signed multiply
    launch(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle("mult");
    chk("mult_cycles", busy_cycles, 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFE);
    MDU_Op = OP_MFHI;
    #1;
    chk("mfhi_out", Out, 32'hFFFF_FFFF);
    MDU_Op = OP_MFLO;
    #1;
    chk("mflo_out", Out, 32'hFFFF_FFFE);
    MDU_Op = OP_NONE;
    #1;
    chk("none_out", Out, 32'h0);

    // Unsigned multiply
    launch(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle("multu");
    chk("multu_cycles", busy_cycles, 32'd5);
    chk("multu_hi", HI, 32'h0000_0001);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // Signed divide -7 / 2
    launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div");
    chk("div_cycles", busy_cycles, 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // Signed divide overflow
    launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("divovf");
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0);

    // Unsigned divide 100 / 7
    launch(OP_DIVU, 32'd100, 32'd7);
    wait_idle("divu");
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // MTHI / MTLO then divide by zero
    drive(OP_MTHI, 32'h11, '0, 1'b0, 1'b0);
    tick();
    chk("mthi_hi", HI, 32'h11);
    drive(OP_MTLO, 32'h22, '0, 1'b0, 1'b0);
    tick();
    chk("mtlo_lo", LO, 32'h22);
    chk("mtlo_hi_kept", HI, 32'h11);
    launch(OP_DIVU, 32'd7, 32'd0);
    wait_idle("div0");
    chk("div0_cycles", busy_cycles, 32'd10);
    chk("div0_hi", HI, 32'h11);
    chk("div0_lo", LO, 32'h22);
    MDU_Op = OP_MFLO;
    #1;
    chk("div0_mflo", Out, 32'h22);

    // Start and MTHI while busy are ignored
    launch(OP_MULT, 32'd3, 32'd4);
    tick();
    drive(OP_DIV, 32'd100, 32'd5, 1'b1, 1'b0);
    tick();
    drive(OP_MTHI, 32'hDEAD, '0, 1'b0, 1'b0);
    tick();
    drive(OP_NONE, '0, '0, 1'b0, 1'b0);
    wait_idle("blk");
    chk("blk_cycles", busy_cycles, 32'd5);
    chk("blk_hi", HI, 32'h0);
    chk("blk_lo", LO, 32'd12);

    // Req blocks Start and MTLO
    drive(OP_MULT, 32'd5, 32'd5, 1'b1, 1'b1);
    tick();
    chk("req_busy", {31'b0, Busy}, 32'd0);
    drive(OP_MTLO, 32'h55, '0, 1'b0, 1'b1);
    tick();
    chk("req_lo", LO, 32'd12);
    chk("req_hi", HI, 32'h0);

    // Start with a non-launch op is ignored
    drive(OP_MFHI, 32'd5, 32'd5, 1'b1, 1'b0);
    tick();
    chk("badop_busy", {31'b0, Busy}, 32'd0);
    drive(OP_NONE, '0, '0, 1'b0, 1'b0);

    // Back-to-back launches with no bubble
    launch(OP_MULTU, 32'd6, 32'd7);
    wait_idle("b2b1");
    chk("b2b1_lo", LO, 32'd42);
    launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b2_busy", {31'b0, Busy}, 32'd1);
    wait_idle("b2b2");
    chk("b2b2_cycles", busy_cycles, 32'd5);
    chk("b2b2_hi", HI, 32'h0);
    chk("b2b2_lo", LO, 32'd1);

    // Reset mid-operation aborts with no later commit
    launch(OP_MULT, 32'd5, 32'd5);
    tick();
    tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("rstmid_busy", {31'b0, Busy}, 32'd0);
    chk("rstmid_hi", HI, 32'h0);
    chk("rstmid_lo", LO, 32'h0);
    for (int i = 0; i < 8; i++) tick();
    chk("rstmid_late_lo", LO, 32'h0);
    chk("rstmid_late_busy", {31'b0, Busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
